// File: rtl/pkt_sf_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pkt_sf_if : write/read handshake bundle for pkt_sf_fifo  (rev 1.0) |
// +--------------------------------------------------------------------+
interface pkt_sf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 13
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_eod;
  logic                  wr_abort;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_eod;
  logic                  rd_valid;
  logic                  pkt_avail;
  logic [DEPTH_LOG2:0]   pkt_count;
  logic                  empty;
  logic                  afull;
  logic                  drop_pulse;

  modport master (
    output wr_en, wr_data, wr_eod, wr_abort, rd_en,
    input  rd_data, rd_eod, rd_valid, pkt_avail, pkt_count, empty, afull, drop_pulse
  );

  modport slave (
    input  wr_en, wr_data, wr_eod, wr_abort, rd_en,
    output rd_data, rd_eod, rd_valid, pkt_avail, pkt_count, empty, afull, drop_pulse
  );
endinterface
`default_nettype wire

// File: rtl/pkt_sf_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pkt_sf_fifo : store-and-forward packet FIFO, drops aborted/overflow |
// | packets before the reader can see them                  (rev 1.0)  |
// +--------------------------------------------------------------------+
module pkt_sf_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 13,
  parameter int AFULL_CNT  = 6600
) (
  input  wire logic clk,
  input  wire logic arst_n,
  pkt_sf_if.slave   bus
);
  localparam int              PW        = DEPTH_LOG2 + 1;
  localparam int              DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0]   FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0]   AFULL_LVL = PW'(AFULL_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DISCARD = 2'd2
  } wr_state_t;

  wr_state_t              state, state_nxt;
  logic [PW-1:0]          wr_ptr, cmt_ptr, rd_ptr;
  logic [PW-1:0]          wr_ptr_nxt, cmt_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0]          pkt_count, cnt_nxt;
  logic [DATA_WIDTH:0]    mem [0:DEPTH-1];
  logic [DATA_WIDTH:0]    rd_word;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_eod, rd_valid, empty, afull, drop_pulse;
  logic                   full, mem_we, commit, drop_nxt, rd_acc;

  assign full    = (wr_ptr - rd_ptr) == FULL_CNT;
  assign rd_acc  = bus.rd_en & ~empty;
  assign rd_word = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    cmt_ptr_nxt = cmt_ptr;
    mem_we      = 1'b0;
    commit      = 1'b0;
    drop_nxt    = 1'b0;
    unique case (state)
      IDLE, FILL: begin
        if (state == FILL && bus.wr_abort) begin
          wr_ptr_nxt = cmt_ptr;
          drop_nxt   = 1'b1;
          state_nxt  = IDLE;
        end else if (bus.wr_en) begin
          if (full) begin
            // Rewind so the partial packet never occupies space.
            wr_ptr_nxt = cmt_ptr;
            if (bus.wr_eod) begin
              drop_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DISCARD;
            end
          end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            if (bus.wr_eod) begin
              commit      = 1'b1;
              cmt_ptr_nxt = wr_ptr + PW'(1);
              state_nxt   = IDLE;
            end else begin
              state_nxt = FILL;
            end
          end
        end
      end
      DISCARD: begin
        if (bus.wr_abort || (bus.wr_en && bus.wr_eod)) begin
          wr_ptr_nxt = cmt_ptr;
          drop_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_ptr_nxt = rd_acc ? rd_ptr + PW'(1) : rd_ptr;
  assign cnt_nxt    = pkt_count + PW'(commit) - PW'(rd_acc & rd_word[DATA_WIDTH]);

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {bus.wr_eod, bus.wr_data};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      rd_data    <= '0;
      rd_eod     <= 1'b0;
      rd_valid   <= 1'b0;
      empty      <= 1'b1;
      afull      <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      cmt_ptr    <= cmt_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      pkt_count  <= cnt_nxt;
      rd_valid   <= rd_acc;
      if (rd_acc) begin
        rd_data <= rd_word[DATA_WIDTH-1:0];
        rd_eod  <= rd_word[DATA_WIDTH];
      end
      // Flags are computed from next-state pointers so they track the edge.
      empty      <= (rd_ptr_nxt == cmt_ptr_nxt);
      afull      <= ((wr_ptr_nxt - rd_ptr_nxt) >= AFULL_LVL);
      drop_pulse <= drop_nxt;
    end
  end

  assign bus.rd_data    = rd_data;
  assign bus.rd_eod     = rd_eod;
  assign bus.rd_valid   = rd_valid;
  assign bus.pkt_count  = pkt_count;
  assign bus.pkt_avail  = (pkt_count != '0);
  assign bus.empty      = empty;
  assign bus.afull      = afull;
  assign bus.drop_pulse = drop_pulse;
endmodule
`default_nettype wire

// File: doc/pkt_sf_fifo.md
# pkt_sf_fifo

Store-and-forward packet FIFO, the parametrised successor of the 9-bit data+EOD packet FIFO. It buffers whole packets and exposes a packet only after its last word (EOD) has been written. Packets that are aborted by the writer, or that would overflow the buffer, are discarded without ever reaching the reader. It sits between the MAC/IP receive parsers and the packet consumers, which can then drain `pkt_avail` packets without underrun.

## Interface
- `DATA_WIDTH`, 8: payload bits per word (EOD is carried separately, internally stored as DATA_WIDTH+1).
- `DEPTH_LOG2`, 13: buffer depth = 2^DEPTH_LOG2 words.
- `AFULL_CNT`, 6600: `afull` asserts when used words (committed + in-flight) >= AFULL_CNT; must be < 2^DEPTH_LOG2.
- `clk`  in  1  sole clock, all logic rising-edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  write strobe for `wr_data`/`wr_eod`.
- `wr_data`  in  DATA_WIDTH  write word.
- `wr_eod`  in  1  word is last of packet; qualified by `wr_en`.
- `wr_abort`  in  1  discard the packet in progress; needs no `wr_en`.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_WIDTH  registered read word.
- `rd_eod`  out  1  EOD flag of `rd_data`.
- `rd_valid`  out  1  `rd_data`/`rd_eod` valid this cycle.
- `pkt_avail`  out  1  `pkt_count` != 0.
- `pkt_count`  out  DEPTH_LOG2+1  committed packets not yet fully read.
- `empty`  out  1  no committed unread words.
- `afull`  out  1  almost-full, see AFULL_CNT.
- `drop_pulse`  out  1  one-cycle pulse per discarded packet (abort or overflow).

## Operation
- Pointers are DEPTH_LOG2+1 bits, with the MSB as the wrap bit: `wr_ptr` (speculative), `cmt_ptr` (committed write), `rd_ptr`.
- Full when `wr_ptr - rd_ptr == 2^DEPTH_LOG2`. `empty` = (`rd_ptr == cmt_ptr`).
- Write FSM states are IDLE, FILL and DISCARD.
  - IDLE, `wr_en` & !`wr_eod`: store the word, `wr_ptr`++ and go to FILL.
  - IDLE, `wr_en` & `wr_eod`: store the word and commit (`cmt_ptr` <= `wr_ptr`+1). Stay in IDLE.
  - FILL, `wr_en`: store the word, `wr_ptr`++. If `wr_eod`, commit and return to IDLE.
  - Any state, `wr_en` while full: do not store the word. Set `wr_ptr` <= `cmt_ptr`. If `wr_eod`, pulse `drop_pulse` and go to IDLE; otherwise go to DISCARD.
  - DISCARD: ignore written words. On `wr_en`&`wr_eod`, pulse `drop_pulse` and go to IDLE.
  - `wr_abort` in FILL or DISCARD: set `wr_ptr` <= `cmt_ptr`, pulse `drop_pulse`, go to IDLE. Abort overrides `wr_en`/`wr_eod` in the same cycle. `wr_abort` in IDLE has no effect and gives no pulse.
- Read side: `rd_en` is accepted only when !`empty`. On accept, the word at `rd_ptr` is registered out and `rd_ptr`++. `rd_en` while empty is ignored: `rd_valid` stays 0 and `rd_data` holds.
- `pkt_count`: +1 on commit, -1 when an accepted read carries EOD. If both happen in one cycle, the count is unchanged. It cannot overflow because every packet is at least 1 word.
- Used words for `afull` = `wr_ptr - rd_ptr`, so in-flight words are included.
- A packet longer than 2^DEPTH_LOG2 words always overflows and is dropped.

## Timing
- Reset values: `rd_data`=0, `rd_eod`=0, `rd_valid`=0, `pkt_avail`=0, `pkt_count`=0, `empty`=1, `afull`=0, `drop_pulse`=0. All pointers are 0 and the FSM is in IDLE. Memory contents are don't-care.
- Read latency is 1: `rd_en` accepted in cycle N gives `rd_valid`=1 with data in cycle N+1.
- Commit to visibility is 1 cycle: an EOD write in cycle N gives `empty`=0 and `pkt_avail`=1 from cycle N+1. A simultaneous read of the same address is not possible.
- `drop_pulse` is registered and is high in the cycle after the abort or dropping EOD.
- `afull`, `empty` and `pkt_count` are registered and reflect pointer state after the previous edge.
- Reset mid-packet discards all contents, including committed packets. The first write after reset release starts in IDLE.
- Simultaneous write and read in any state are fully supported, including at the wrap boundary.

## Test plan
- Write one 3-word packet (0xA1, 0xA2, 0xA3+EOD). Check `pkt_avail` rises the cycle after EOD. Read 3 words and check `rd_eod` only on 0xA3, then `pkt_count`=0 and `empty`=1.
- Write 2 words, then `wr_abort`. Check `drop_pulse` for 1 cycle, `empty` stays 1, and a following 1-word packet 0x55+EOD is read back alone.
- DEPTH_LOG2=4: commit a 10-word packet, then write a 10-word packet. Check the overflow word is rejected, the FSM enters DISCARD, `drop_pulse` fires on EOD, and only the first packet is readable.
- DEPTH_LOG2=4: run 20 back-to-back 5-word packets with concurrent reads. Check data integrity across pointer wrap and that `pkt_count` never exceeds 3.
- A commit and a read of the last EOD word in the same cycle leave `pkt_count` unchanged at 1. `rd_en` while empty gives `rd_valid`=0.
- Assert `arst_n` low mid-FILL with 2 packets committed. Check all reset values immediately, asynchronously, and that a new packet after release reads correctly.
